// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator for a word-addressed, synchronous-read data memory.
// Handles byte/halfword loads by lane extraction and sub-word stores by read-modify-write.
module load_store_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        isStore,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] storeData,
  output logic        ready,
  output logic        done,
  output logic        loadValid,
  output logic [31:0] loadData,
  output logic        fault,
  output logic        memRead,
  output logic        memWrite,
  output logic [31:0] memAddress,
  output logic [31:0] memWriteData,
  input  logic [31:0] memReadData
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    RESP  = 3'd2,
    WR    = 3'd3,
    MERGE = 3'd4,
    ERR   = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic        store_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] sdata_q;

  logic        accept;
  logic        req_illegal;
  logic        req_misaligned;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_ext;
  logic [31:0] merged;

  assign accept = req && (state_q == IDLE);

  // Legality is judged on the live request so the IDLE transition can pick ERR directly.
  always_comb begin
    req_illegal    = isStore ? (funct3 >= 3'b011)
                             : ((funct3 == 3'b011) || (funct3[2:1] == 2'b11));
    req_misaligned = ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00)) ||
                     ((funct3[1:0] == 2'b01) && addr[0]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      store_q  <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= 32'h0;
      sdata_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        store_q  <= isStore;
        funct3_q <= funct3;
        addr_q   <= addr;
        sdata_q  <= storeData;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (req_illegal || req_misaligned)
            state_d = ERR;
          else if (isStore && (funct3 == 3'b010))
            state_d = WR;
          else
            state_d = RD;
        end
      end
      RD:      state_d = store_q ? MERGE : RESP;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    lane_byte = memReadData[{addr_q[1:0], 3'b000} +: 8];
    lane_half = addr_q[1] ? memReadData[31:16] : memReadData[15:0];
    case (funct3_q)
      3'b000:  load_ext = {{24{lane_byte[7]}}, lane_byte};
      3'b001:  load_ext = {{16{lane_half[15]}}, lane_half};
      3'b100:  load_ext = {24'h0, lane_byte};
      3'b101:  load_ext = {16'h0, lane_half};
      default: load_ext = memReadData;
    endcase
  end

  // Per-byte merge: sb hits one lane, sh hits the lane pair selected by addr[1].
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic       hit;
      logic [7:0] src;
      assign hit = (funct3_q[1:0] == 2'b00) ? (addr_q[1:0] == 2'(gi))
                                            : (addr_q[1] == 1'(gi / 2));
      if (gi % 2 == 1) begin : g_odd
        assign src = funct3_q[0] ? sdata_q[15:8] : sdata_q[7:0];
      end else begin : g_even
        assign src = sdata_q[7:0];
      end
      assign merged[8*gi +: 8] = hit ? src : memReadData[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    ready        = (state_q == IDLE);
    done         = 1'b0;
    loadValid    = 1'b0;
    loadData     = 32'h0;
    fault        = 1'b0;
    memRead      = 1'b0;
    memWrite     = 1'b0;
    memWriteData = 32'h0;
    memAddress   = (state_q == IDLE) ? 32'h0 : {addr_q[31:2], 2'b00};
    case (state_q)
      RD:    memRead = 1'b1;
      RESP: begin
        loadValid = 1'b1;
        done      = 1'b1;
        loadData  = load_ext;
      end
      WR: begin
        memWrite     = 1'b1;
        done         = 1'b1;
        memWriteData = sdata_q;
      end
      MERGE: begin
        memWrite     = 1'b1;
        done         = 1'b1;
        memWriteData = merged;
      end
      ERR: begin
        fault = 1'b1;
        done  = 1'b1;
      end
      default: ;
    endcase
    // Reset suppresses every strobe so an in-flight write never reaches memory.
    if (reset) begin
      done         = 1'b0;
      loadValid    = 1'b0;
      loadData     = 32'h0;
      fault        = 1'b0;
      memRead      = 1'b0;
      memWrite     = 1'b0;
      memWriteData = 32'h0;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: transaction-level model predicts every output cycle,
// plus literal checks on load results, store words and fault/write counts.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset, req, isStore;
  logic [2:0]  funct3;
  logic [31:0] addr, storeData;
  logic        ready, done, loadValid, fault, memRead, memWrite;
  logic [31:0] loadData, memAddress, memWriteData;
  logic [31:0] memReadData = 32'h0;

  load_store_unit dut (
    .clk(clk), .reset(reset), .req(req), .isStore(isStore), .funct3(funct3),
    .addr(addr), .storeData(storeData), .ready(ready), .done(done),
    .loadValid(loadValid), .loadData(loadData), .fault(fault),
    .memRead(memRead), .memWrite(memWrite), .memAddress(memAddress),
    .memWriteData(memWriteData), .memReadData(memReadData)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rdy, dn, lv;
    logic [31:0] ld;
    logic        flt, mr, mw;
    logic [31:0] ma, wd;
    logic        commit;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ram[64];
  logic [31:0] ref_mem[64];
  int          checks = 0, failures = 0;
  int          acc_cnt = 0, mw_cnt = 0, fault_cnt = 0;
  bit          model_ready = 0;
  logic [31:0] last_ld = 0, last_wd = 0, model_ld = 0, model_wd = 0;

  initial begin
    for (int i = 0; i < 64; i++) begin
      ram[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
  end

  // Slave memory: registered read, word write.
  always @(posedge clk) begin
    if (memRead)  memReadData <= ram[memAddress[7:2]];
    if (memWrite) ram[memAddress[7:2]] <= memWriteData;
  end

  function automatic exp_t idle_e();
    exp_t e;
    e = '0;
    e.rdy = 1'b1;
    return e;
  endfunction

  // Model: expands one accepted request into its per-cycle output sequence.
  task automatic push_req(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd);
    exp_t e1, e2;
    logic [31:0] w, b, h, wa, res, mask, put;
    int sz, shb;
    bit bad;
    e1 = '0; e2 = '0;
    wa = {a[31:2], 2'b00};
    sz = int'(f3[1:0]);
    bad = st ? (f3 >= 3) : (f3 == 3 || f3 == 6 || f3 == 7);
    if (sz == 2 && a[1:0] != 0) bad = 1;
    if (sz == 1 && a[0] != 0) bad = 1;
    w = ref_mem[a[7:2]];
    shb = 8 * int'(a[1:0]);
    b = (w >> shb) & 32'hFF;
    h = a[1] ? (w >> 16) : (w & 32'hFFFF);
    e1.ma = wa; e2.ma = wa;
    if (bad) begin
      e1.dn = 1; e1.flt = 1;
      exp_q.push_back(e1);
    end else if (st && f3 == 2) begin
      e1.dn = 1; e1.mw = 1; e1.wd = sd; e1.commit = 1;
      model_wd = sd;
      exp_q.push_back(e1);
    end else if (!st) begin
      case (f3)
        3'b000:  res = (b >= 128) ? (b | 32'hFFFFFF00) : b;
        3'b001:  res = (h >= 32768) ? (h | 32'hFFFF0000) : h;
        3'b100:  res = b;
        3'b101:  res = h;
        default: res = w;
      endcase
      model_ld = res;
      e1.mr = 1;
      e2.dn = 1; e2.lv = 1; e2.ld = res;
      exp_q.push_back(e1);
      exp_q.push_back(e2);
    end else begin
      if (sz == 0) begin
        mask = 32'hFF << shb;
        put = (sd & 32'hFF) << shb;
      end else begin
        mask = 32'hFFFF << (16 * int'(a[1]));
        put = (sd & 32'hFFFF) << (16 * int'(a[1]));
      end
      res = (w & ~mask) | put;
      model_wd = res;
      e1.mr = 1;
      e2.dn = 1; e2.mw = 1; e2.wd = res; e2.commit = 1;
      exp_q.push_back(e1);
      exp_q.push_back(e2);
    end
  endtask

  always @(posedge clk) begin
    if (!reset && req && model_ready) begin
      push_req(isStore, funct3, addr, storeData);
      acc_cnt++;
    end
  end

  // Single compare process: one comparison per cycle at the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      exp_q.delete();
      model_ready = 0;
      checks++;
      if ({memRead, memWrite, done, loadValid, fault} != 5'b0 || loadData != 0 || memWriteData != 0) begin
        failures++;
        $display("FAIL reset_quiet t=%0t act mr=%b mw=%b done=%b lv=%b flt=%b ld=%h wd=%h required all 0",
                 $time, memRead, memWrite, done, loadValid, fault, loadData, memWriteData);
      end
    end else begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        model_ready = 0;
      end else begin
        e = idle_e();
        model_ready = 1;
      end
      checks++;
      if (ready !== e.rdy || done !== e.dn || loadValid !== e.lv || loadData !== e.ld ||
          fault !== e.flt || memRead !== e.mr || memWrite !== e.mw ||
          memAddress !== e.ma || memWriteData !== e.wd) begin
        failures++;
        $display("FAIL cycle t=%0t act rdy=%b dn=%b lv=%b ld=%h flt=%b mr=%b mw=%b ma=%h wd=%h req rdy=%b dn=%b lv=%b ld=%h flt=%b mr=%b mw=%b ma=%h wd=%h",
                 $time, ready, done, loadValid, loadData, fault, memRead, memWrite, memAddress, memWriteData,
                 e.rdy, e.dn, e.lv, e.ld, e.flt, e.mr, e.mw, e.ma, e.wd);
      end
      if (e.commit) ref_mem[e.ma[7:2]] = e.wd;
      if (loadValid) last_ld = loadData;
      if (memWrite) begin
        last_wd = memWriteData;
        mw_cnt++;
      end
      if (fault) fault_cnt++;
    end
  end

  task automatic lit_check(input string nm, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s act=%h req=%h", nm, act, req_v);
    end
  endtask

  task automatic accept_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] sd, input string nm, output bit got);
    int old;
    old = acc_cnt;
    got = 0;
    isStore = st; funct3 = f3; addr = a; storeData = sd; req = 1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (acc_cnt != old) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL %s accept_timeout act=none req=accepted", nm);
      req = 0;
    end
  endtask

  // chk: 0 none, 1 load result, 2 written word.
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd,
                       input bit hold, input int chk, input logic [31:0] lit, input string nm);
    bit got;
    accept_req(st, f3, a, sd, nm, got);
    if (!got) return;
    if (!hold) req = 0;
    repeat (2) @(posedge clk);
    #1 req = 0;
    @(negedge clk);
    #1;
    if (chk == 1) begin
      lit_check({nm, "_dut"}, last_ld, lit);
      lit_check({nm, "_model"}, model_ld, lit);
    end else if (chk == 2) begin
      lit_check({nm, "_dut"}, last_wd, lit);
      lit_check({nm, "_model"}, model_wd, lit);
    end
    $display("txn %s st=%0d f3=%0d addr=%h data=%h", nm, st, f3, a, sd);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    int mw_snap;
    reset = 1; req = 1; isStore = 1; funct3 = 3'b010; addr = 32'h20; storeData = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1 reset = 0; req = 0;
    repeat (3) @(posedge clk);
    #1;
    lit_check("post_reset_writes", 32'(mw_cnt), 32'd0);

    issue(1, 3'b010, 32'h10, 32'h80FF7F01, 0, 2, 32'h80FF7F01, "sw_10");
    issue(0, 3'b010, 32'h10, 32'h0, 0, 1, 32'h80FF7F01, "lw_10");
    issue(0, 3'b000, 32'h13, 32'h0, 0, 1, 32'hFFFFFF80, "lb_13");
    issue(0, 3'b100, 32'h13, 32'h0, 0, 1, 32'h00000080, "lbu_13");
    issue(0, 3'b001, 32'h12, 32'h0, 0, 1, 32'hFFFF80FF, "lh_12");
    issue(0, 3'b101, 32'h10, 32'h0, 0, 1, 32'h00007F01, "lhu_10");
    issue(0, 3'b000, 32'h11, 32'h0, 0, 1, 32'h0000007F, "lb_11");
    issue(1, 3'b000, 32'h11, 32'hCAFE00AB, 0, 2, 32'h80FFAB01, "sb_11");
    issue(1, 3'b001, 32'h12, 32'hBEEF1234, 0, 2, 32'h1234AB01, "sh_12");
    issue(0, 3'b010, 32'h10, 32'h0, 0, 1, 32'h1234AB01, "lw_10b");

    issue(0, 3'b010, 32'h06, 32'h0, 0, 0, 32'h0, "lw_06_mis");
    issue(1, 3'b001, 32'h13, 32'h5555, 0, 0, 32'h0, "sh_13_mis");
    issue(0, 3'b011, 32'h10, 32'h0, 0, 0, 32'h0, "ld_011_ill");
    lit_check("fault_count", 32'(fault_cnt), 32'd3);

    mw_snap = mw_cnt;
    issue(1, 3'b000, 32'h20, 32'h0000005A, 1, 2, 32'h0000005A, "sb_20_held");
    lit_check("held_one_write", 32'(mw_cnt - mw_snap), 32'd1);
    issue(0, 3'b010, 32'h20, 32'h0, 0, 1, 32'h0000005A, "lw_20");

    // Reset lands in the RD cycle of an sb; the write must never happen.
    mw_snap = mw_cnt;
    accept_req(1, 3'b000, 32'h10, 32'h00000055, "sb_10_abort", got);
    req = 0;
    if (got) begin
      reset = 1;
      @(posedge clk);
      #1 reset = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    lit_check("abort_no_write", 32'(mw_cnt - mw_snap), 32'd0);
    $display("txn sb_10_abort st=1 f3=0 addr=00000010 data=00000055");
    issue(0, 3'b010, 32'h10, 32'h0, 0, 1, 32'h1234AB01, "lw_10_after_abort");

    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
